// File: rtl/div_pkg.sv
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DIV_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_FIN  = 2'd3
    } div_state_t;

    // Quotient reported for a zero divisor: all ones of the operand width.
    function automatic logic [31:0] div_zero_quotient(input int unsigned width);
        return 32'hFFFF_FFFF >> (32 - width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division step on {R,Q}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_r,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_r_shift;
    logic [WIDTH+1:0] w_t;
    logic             w_fit;

    assign w_r_shift = {i_r[WIDTH-1:0], i_q[WIDTH-1]};

    // One spare top bit keeps the borrow unambiguous even for a full-width R'.
    assign w_t   = {i_r, i_q[WIDTH-1]} - {2'b00, i_divisor};
    assign w_fit = ~w_t[WIDTH+1];

    assign o_r = w_fit ? w_t[WIDTH:0] : w_r_shift;
    assign o_q = {i_q[WIDTH-2:0], w_fit};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module      : seq_divider
//  Description : Sequential unsigned restoring divider, one quotient bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             DONE,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int               c_CW       = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]  c_CNT_INIT = c_CW'(WIDTH);
    localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
    localparam logic [WIDTH-1:0] c_DBZ_Q    = WIDTH'(div_zero_quotient(WIDTH));

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;
    logic [WIDTH:0]   w_next_r;
    logic [WIDTH-1:0] w_next_q;
    logic             w_div_zero;

    assign w_div_zero = (r_divisor == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_r       (r_acc),
        .i_q       (r_q),
        .i_divisor (r_divisor),
        .o_r       (w_next_r),
        .o_q       (w_next_q)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (valid) w_next_state = S_LOAD;
            S_LOAD: w_next_state = w_div_zero ? S_FIN : S_ITER;
            S_ITER: if (r_cnt == c_CNT_ONE) w_next_state = S_FIN;
            S_FIN:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                    end
                end
                S_LOAD: begin
                    r_acc <= '0;
                    r_q   <= r_dividend;
                    r_cnt <= c_CNT_INIT;
                    if (w_div_zero) begin
                        r_quotient  <= c_DBZ_Q;
                        r_remainder <= r_dividend;
                        r_dbz       <= 1'b1;
                    end
                end
                S_ITER: begin
                    r_acc <= w_next_r;
                    r_q   <= w_next_q;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    // Publish results on the same edge the final step lands.
                    if (r_cnt == c_CNT_ONE) begin
                        r_quotient  <= w_next_q;
                        r_remainder <= w_next_r[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == S_LOAD) || (r_state == S_ITER);
    assign DONE        = (r_state == S_FIN);
    assign div_by_zero = r_dbz;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Directed and randomized self-checking bench for seq_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         DONE;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           lat;
    int           done_cnt;
    logic         busy1;
    logic         ovl;
    logic [W-1:0] rq;
    logic [W-1:0] rr;
    logic         rdbz;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .DONE        (DONE),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, wait for DONE, capture results, step back to IDLE.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        valid    = 1'b1;
        tick();
        valid    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat      = 1;
        busy1    = busy;
        ovl      = busy && DONE;
        while (!DONE && lat < 40) begin
            tick();
            lat++;
            if (busy && DONE) ovl = 1'b1;
        end
        rq   = quotient;
        rr   = remainder;
        rdbz = div_by_zero;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        valid    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_dbz",  32'(div_by_zero), 32'd0);
        check("reset_q",    32'(quotient), 32'd0);
        check("reset_r",    32'(remainder), 32'd0);
        rst = 1'b0;
        tick();

        run_div(8'd100, 8'd7);
        check("basic_lat",   32'(lat), 32'd10);
        check("basic_busy1", 32'(busy1), 32'd1);
        check("basic_ovl",   32'(ovl), 32'd0);
        check("basic_q",     32'(rq), 32'd14);
        check("basic_r",     32'(rr), 32'd2);
        check("basic_dbz",   32'(rdbz), 32'd0);

        run_div(8'd255, 8'd1);
        check("max_q", 32'(rq), 32'd255);
        check("max_r", 32'(rr), 32'd0);
        run_div(8'd5, 8'd9);
        check("small_q", 32'(rq), 32'd0);
        check("small_r", 32'(rr), 32'd5);
        run_div(8'd0, 8'd3);
        check("zero_q", 32'(rq), 32'd0);
        check("zero_r", 32'(rr), 32'd0);

        run_div(8'd37, 8'd0);
        check("dbz_lat", 32'(lat), 32'd2);
        check("dbz_q",   32'(rq), 32'd255);
        check("dbz_r",   32'(rr), 32'd37);
        check("dbz_flag", 32'(rdbz), 32'd1);
        run_div(8'd9, 8'd3);
        check("after_dbz_q",   32'(rq), 32'd3);
        check("after_dbz_r",   32'(rr), 32'd0);
        check("after_dbz_flag", 32'(rdbz), 32'd0);

        // Request pulsed mid-operation must be dropped.
        dividend = 8'd100;
        divisor  = 8'd7;
        valid    = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        tick();
        check("hold_q_busy", 32'(quotient), 32'd3);
        dividend = 8'd200;
        divisor  = 8'd9;
        valid    = 1'b1;
        tick();
        valid = 1'b0;
        lat   = 5;
        while (!DONE && lat < 40) begin
            tick();
            lat++;
        end
        check("ign_lat", 32'(lat), 32'd10);
        check("ign_q",   32'(quotient), 32'd14);
        check("ign_r",   32'(remainder), 32'd2);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DONE) done_cnt++;
        end
        check("ign_no_second_done", 32'(done_cnt), 32'd0);

        // Reset asserted in cycle 5 of an operation aborts it.
        dividend = 8'd200;
        divisor  = 8'd9;
        valid    = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(DONE), 32'd0);
        check("midrst_q",    32'(quotient), 32'd0);
        check("midrst_r",    32'(remainder), 32'd0);
        check("midrst_dbz",  32'(div_by_zero), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DONE || busy) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);

        // Valid coincident with reset is not accepted.
        rst   = 1'b1;
        valid = 1'b1;
        tick();
        rst   = 1'b0;
        valid = 1'b0;
        tick();
        check("rst_valid_busy", 32'(busy), 32'd0);

        run_div(8'd200, 8'd9);
        check("post_rst_q", 32'(rq), 32'd22);
        check("post_rst_r", 32'(rr), 32'd2);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(1, 255));
            run_div(a, b);
            check("rand_lat", 32'(lat), 32'd10);
            check("rand_q", 32'(rq), 32'(a / b));
            check("rand_r", 32'(rr), 32'(a % b));
            check("rand_identity", 32'(rq) * 32'(b) + 32'(rr), 32'(a));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
